// File: rtl/sd_block_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sd_block_reader_pkg
//  Description : Shared definitions for the SD block read path. Holds the
//                token byte values, err_code encodings, reader state
//                encodings and a small token classification helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package sd_block_reader_pkg;

   // Token bytes seen on MISO
   localparam logic [7:0] SD_TOKEN_START = 8'hFE;
   localparam logic [7:0] SD_IDLE_BYTE   = 8'hFF;

   // err_code encodings
   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_TOKEN   = 2'b10;

   // Reader state encodings
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HUNT   = 3'd1,
      ST_DATA   = 3'd2,
      ST_CRC    = 3'd3,
      ST_FINISH = 3'd4
   } state_t;

   // A data error token has an all-zero upper nibble.
   function automatic logic is_error_token(input logic [7:0] b);
      return (b[7:4] == 4'h0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sd_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sd_byte_fifo
//  Description : Synchronous byte FIFO. Write at cycle T is visible at the
//                read side at T+1. Push and pop in the same cycle are
//                accepted at any fill level; pop on empty is ignored.
//  Ports       : clk, rst      - clock, synchronous active-high reset (flush)
//                push, wr_data - write request and data
//                pop, rd_data  - read request and head byte (0 when empty)
//                full, empty   - fill flags
//                count         - current number of entries
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [7:0]                 wr_data,
   input  logic                       pop,
   output logic [7:0]                 rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int c_aw = $clog2(DEPTH);
   localparam int c_cw = c_aw + 1;

   logic [7:0]      r_mem [DEPTH];
   logic [c_aw-1:0] r_wr_ptr;
   logic [c_aw-1:0] r_rd_ptr;
   logic [c_cw-1:0] r_count;

   logic w_pop_ok;
   logic w_push_ok;

   assign empty     = (r_count == '0);
   assign full      = (r_count == c_cw'(DEPTH));
   assign count     = r_count;
   assign w_pop_ok  = pop && !empty;
   // A pop in the same cycle frees the slot, so push is legal even when full.
   assign w_push_ok = push && (!full || w_pop_ok);
   assign rd_data   = empty ? 8'h00 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/sd_block_reader.sv
`default_nettype none
// ============================================================================
//  Module      : sd_block_reader
//  Description : Reads one SD data block after CMD17. Polls the SPI byte
//                engine for the start token, streams the payload into an
//                output FIFO, captures the 16-bit CRC and reports timeout
//                or error-token aborts. Payload requests are only issued
//                when a FIFO slot is free, so a stalled consumer stalls SPI.
//  Ports       : MasterCLK, Reset          - clock, sync active-high reset
//                start                     - begin one block read
//                byte_req/byte_valid/byte_data - SPI byte engine handshake
//                out_valid/out_data/out_ready  - payload stream to consumer
//                busy, done, error, err_code   - status
//                crc                       - last received block CRC
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_block_reader
   import sd_block_reader_pkg::*;
#(
   parameter int BLOCK_BYTES   = 512,
   parameter int TOKEN_TIMEOUT = 1024,
   parameter int FIFO_DEPTH    = 16
) (
   input  logic        MasterCLK,
   input  logic        Reset,
   input  logic        start,
   output logic        byte_req,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        out_valid,
   output logic [7:0]  out_data,
   input  logic        out_ready,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [15:0] crc
);

   localparam int c_cnt_max = (TOKEN_TIMEOUT > BLOCK_BYTES) ? TOKEN_TIMEOUT : BLOCK_BYTES;
   localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
   localparam int c_fcw     = $clog2(FIFO_DEPTH) + 1;

   state_t               r_state;
   logic                 r_outstanding;
   logic                 r_byte_req;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_error;
   logic [1:0]           r_err_code;
   logic [15:0]          r_crc;
   logic [7:0]           r_crc_hi;
   logic                 r_crc_second;
   logic [c_cnt_w-1:0]   r_count;

   logic                 w_accept;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_empty;
   logic [c_fcw-1:0]     w_fifo_count;
   logic [c_fcw-1:0]     w_fill_after_push;

   // Only a strobe answering our own request is meaningful.
   assign w_accept          = byte_valid && r_outstanding;
   assign w_push            = w_accept && (r_state == ST_DATA);
   assign w_pop             = out_valid && out_ready;
   assign w_fill_after_push = w_fifo_count + c_fcw'(1);

   sd_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (MasterCLK),
      .rst     (Reset),
      .push    (w_push),
      .wr_data (byte_data),
      .pop     (w_pop),
      .rd_data (out_data),
      .full    (w_full),
      .empty   (w_empty),
      .count   (w_fifo_count)
   );

   assign out_valid = !w_empty;
   assign byte_req  = r_byte_req;
   assign busy      = r_busy;
   assign done      = r_done;
   assign error     = r_error;
   assign err_code  = r_err_code;
   assign crc       = r_crc;

   always_ff @(posedge MasterCLK) begin
      if (Reset) begin
         r_state       <= ST_IDLE;
         r_outstanding <= 1'b0;
         r_byte_req    <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_error       <= 1'b0;
         r_err_code    <= ERR_NONE;
         r_crc         <= 16'h0000;
         r_crc_hi      <= 8'h00;
         r_crc_second  <= 1'b0;
         r_count       <= '0;
      end else begin
         r_byte_req <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state       <= ST_HUNT;
                  r_busy        <= 1'b1;
                  r_byte_req    <= 1'b1;
                  r_outstanding <= 1'b1;
                  r_count       <= '0;
                  r_err_code    <= ERR_NONE;
                  r_crc_second  <= 1'b0;
               end
            end

            ST_HUNT: begin
               if (w_accept) begin
                  r_outstanding <= 1'b0;
                  if (byte_data == SD_TOKEN_START) begin
                     r_state <= ST_DATA;
                     r_count <= '0;
                  end else if (is_error_token(byte_data)) begin
                     r_state    <= ST_IDLE;
                     r_busy     <= 1'b0;
                     r_error    <= 1'b1;
                     r_err_code <= ERR_TOKEN;
                  end else if (r_count == c_cnt_w'(TOKEN_TIMEOUT - 1)) begin
                     r_state    <= ST_IDLE;
                     r_busy     <= 1'b0;
                     r_error    <= 1'b1;
                     r_err_code <= ERR_TIMEOUT;
                  end else begin
                     // Idle fill and unknown bytes both keep polling.
                     r_count       <= r_count + 1'b1;
                     r_byte_req    <= 1'b1;
                     r_outstanding <= 1'b1;
                  end
               end
            end

            ST_DATA: begin
               if (w_accept) begin
                  r_outstanding <= 1'b0;
                  if (r_count == c_cnt_w'(BLOCK_BYTES - 1)) begin
                     r_state       <= ST_CRC;
                     r_count       <= '0;
                     r_byte_req    <= 1'b1;
                     r_outstanding <= 1'b1;
                  end else begin
                     r_count <= r_count + 1'b1;
                     // The byte being pushed now already occupies a slot.
                     if (w_fill_after_push < c_fcw'(FIFO_DEPTH)) begin
                        r_byte_req    <= 1'b1;
                        r_outstanding <= 1'b1;
                     end
                  end
               end else if (!r_outstanding && !w_full) begin
                  r_byte_req    <= 1'b1;
                  r_outstanding <= 1'b1;
               end
            end

            ST_CRC: begin
               if (w_accept) begin
                  if (!r_crc_second) begin
                     r_crc_hi      <= byte_data;
                     r_crc_second  <= 1'b1;
                     r_byte_req    <= 1'b1;
                     r_outstanding <= 1'b1;
                  end else begin
                     r_outstanding <= 1'b0;
                     r_crc         <= {r_crc_hi, byte_data};
                     r_done        <= 1'b1;
                     r_busy        <= 1'b0;
                     r_state       <= ST_FINISH;
                  end
               end
            end

            ST_FINISH: begin
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
